// File: rtl/tdm_pkg.sv
// tdm_pkg: shared state encoding and slot geometry for the TDM demultiplexer.
package tdm_pkg;
    typedef enum logic {HUNT, LOCK} state_t;
    localparam int N_SLOTS = 4;
    localparam int SLOT_W = 2;
endpackage

// File: rtl/tdm_slot_cnt.sv
// tdm_slot_cnt: 2-bit slot index with clear, load-to-1 and increment-on-enable.
module tdm_slot_cnt
    import tdm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load1,
    input  logic              inc,
    output logic [SLOT_W-1:0] cnt
);
    logic [SLOT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = clr ? '0 : load1 ? SLOT_W'(1) : inc ? cnt_q + SLOT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/tdm_demux.sv
// tdm_demux: hunts for a slot-0 frame marker, then deserialises 4-slot TDM words
// into a registered parallel output with framing-error detection.
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int FRAME_CHECK = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             en,
    input  logic             frame,
    output logic [3:0]       O,
    output logic             o_valid,
    output logic             S1,
    output logic             S2,
    output logic             locked,
    output logic             sync_err,
    output logic [CNT_W-1:0] frame_cnt
);
    state_t             state_q, state_d;
    logic [N_SLOTS-1:0] shadow_q, shadow_d, o_q, o_d;
    logic               o_valid_q, o_valid_d, sync_err_q, sync_err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SLOT_W-1:0]  slot;
    logic               slot_clr, slot_load1, slot_inc;

    tdm_slot_cnt u_slot (
        .clk  (clk),
        .rst  (rst),
        .clr  (slot_clr),
        .load1(slot_load1),
        .inc  (slot_inc),
        .cnt  (slot)
    );

    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        o_d        = o_q;
        o_valid_d  = 1'b0;
        sync_err_d = 1'b0;
        cnt_d      = cnt_q;
        slot_clr   = 1'b0;
        slot_load1 = 1'b0;
        slot_inc   = 1'b0;
        if (en) begin
            if (state_q == HUNT) begin
                if (frame) begin
                    state_d    = LOCK;
                    shadow_d   = {{(N_SLOTS-1){1'b0}}, din};
                    slot_load1 = 1'b1;
                end
            end else if (frame && slot != '0) begin
                // Early marker: restart the word with this bit as slot 0.
                sync_err_d = 1'b1;
                shadow_d   = {{(N_SLOTS-1){1'b0}}, din};
                slot_load1 = 1'b1;
            end else if (!frame && slot == '0 && FRAME_CHECK != 0) begin
                sync_err_d = 1'b1;
                state_d    = HUNT;
                slot_clr   = 1'b1;
            end else begin
                shadow_d[slot] = din;
                slot_inc       = 1'b1;
                if (slot == SLOT_W'(N_SLOTS-1)) begin
                    o_d       = shadow_d;
                    o_valid_d = 1'b1;
                    cnt_d     = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= HUNT;
            shadow_q   <= '0;
            o_q        <= '0;
            o_valid_q  <= 1'b0;
            sync_err_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            o_q        <= o_d;
            o_valid_q  <= o_valid_d;
            sync_err_q <= sync_err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign O         = o_q;
    assign o_valid   = o_valid_q;
    assign sync_err  = sync_err_q;
    assign frame_cnt = cnt_q;
    assign locked    = (state_q == LOCK);
    assign S1        = slot[1];
    assign S2        = slot[0];
endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: directed and random stimulus on two configurations, checked
// against a word-position model of the framing rules.
module tb_tdm_demux;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic din = 1'b0;
    logic en = 1'b0;
    logic frame = 1'b0;

    logic [1:0][3:0] o_w;
    logic [1:0]      v_w, s1_w, s2_w, lk_w, err_w;
    logic [7:0]      cnt0;
    logic [1:0]      cnt1;

    int n_tests = 0;
    int n_fail = 0;

    bit       m_lock [2];
    int       m_pos  [2];
    bit [3:0] m_bits [2];
    bit [3:0] m_o    [2];
    bit       m_valid[2];
    bit       m_err  [2];
    int       m_cnt  [2];
    int       m_cmax [2] = '{255, 3};
    bit       m_fc   [2] = '{1'b1, 1'b0};

    always #5 clk = ~clk;

    tdm_demux #(.FRAME_CHECK(1), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .din(din), .en(en), .frame(frame),
        .O(o_w[0]), .o_valid(v_w[0]), .S1(s1_w[0]), .S2(s2_w[0]),
        .locked(lk_w[0]), .sync_err(err_w[0]), .frame_cnt(cnt0)
    );

    tdm_demux #(.FRAME_CHECK(0), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .din(din), .en(en), .frame(frame),
        .O(o_w[1]), .o_valid(v_w[1]), .S1(s1_w[1]), .S2(s2_w[1]),
        .locked(lk_w[1]), .sync_err(err_w[1]), .frame_cnt(cnt1)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_lock[i] = 0; m_pos[i] = 0; m_bits[i] = '0; m_o[i] = '0;
            m_valid[i] = 0; m_err[i] = 0; m_cnt[i] = 0;
        end
    endtask

    task automatic model_step(input bit e, input bit d, input bit f);
        for (int i = 0; i < 2; i++) begin
            m_valid[i] = 0;
            m_err[i] = 0;
            if (!e) continue;
            if (!m_lock[i]) begin
                if (f) begin m_lock[i] = 1; m_bits[i] = 4'(d); m_pos[i] = 1; end
            end else if (f && m_pos[i] != 0) begin
                m_err[i] = 1; m_bits[i] = 4'(d); m_pos[i] = 1;
            end else if (!f && m_pos[i] == 0 && m_fc[i]) begin
                m_err[i] = 1; m_lock[i] = 0; m_pos[i] = 0;
            end else begin
                m_bits[i][m_pos[i]] = d;
                m_pos[i]++;
                if (m_pos[i] == 4) begin
                    m_o[i] = m_bits[i];
                    m_valid[i] = 1;
                    if (m_cnt[i] < m_cmax[i]) m_cnt[i]++;
                    m_pos[i] = 0;
                end
            end
        end
    endtask

    task automatic check_all();
        check("O0", int'(o_w[0]), int'(m_o[0]));
        check("O1", int'(o_w[1]), int'(m_o[1]));
        check("valid0", int'(v_w[0]), int'(m_valid[0]));
        check("valid1", int'(v_w[1]), int'(m_valid[1]));
        check("err0", int'(err_w[0]), int'(m_err[0]));
        check("err1", int'(err_w[1]), int'(m_err[1]));
        check("locked0", int'(lk_w[0]), int'(m_lock[0]));
        check("locked1", int'(lk_w[1]), int'(m_lock[1]));
        check("slot0", int'({s1_w[0], s2_w[0]}), m_pos[0]);
        check("slot1", int'({s1_w[1], s2_w[1]}), m_pos[1]);
        check("cnt0", int'(cnt0), m_cnt[0]);
        check("cnt1", int'(cnt1), m_cnt[1]);
    endtask

    task automatic cycle(input bit e, input bit d, input bit f);
        en = e; din = d; frame = f;
        @(posedge clk);
        #1;
        model_step(e, d, f);
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        model_reset();
        check_all();
        #2;
        rst = 1'b0;
    endtask

    task automatic send_word(input bit [3:0] w, input bit gap);
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, w[k], k == 0);
            if (gap) cycle(1'b0, 1'b0, 1'b0);
        end
    endtask

    int exp_cnt[5] = '{1, 2, 3, 3, 3};

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        send_word(4'b1101, 1'b0);
        check("req033_O", int'(o_w[0]), 13);
        check("req033_valid", int'(v_w[0]), 1);
        check("req033_cnt", int'(cnt0), 1);
        check("req033_locked", int'(lk_w[0]), 1);
        cycle(1'b0, 1'b0, 1'b0);
        check("req033_pulse", int'(v_w[0]), 0);

        cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1);
        check("req034_err", int'(err_w[0]), 1);
        check("req034_O", int'(o_w[0]), 13);
        check("req034_slot", int'({s1_w[0], s2_w[0]}), 1);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        check("req035_err", int'(err_w[0]), 1);
        check("req035_locked", int'(lk_w[0]), 0);
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'(k), 1'b0);
        check("req035_hunt", int'(lk_w[0]), 0);

        do_reset();
        send_word(4'b1010, 1'b1);
        check("req036_O", int'(o_w[0]), 10);

        do_reset();
        cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b0);
        do_reset();
        check("req037_slot", int'({s1_w[0], s2_w[0]}), 0);
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);

        do_reset();
        for (int n = 0; n < 5; n++) begin
            send_word(4'($urandom), 1'b0);
            check("req038_cnt", int'(cnt1), exp_cnt[n]);
        end

        for (int n = 0; n < 3000; n++) begin
            bit f;
            if ($urandom_range(0, 199) == 0) do_reset();
            f = ($urandom_range(0, 9) == 0) ? 1'($urandom) : (m_pos[0] == 0);
            cycle($urandom_range(0, 3) != 0, 1'($urandom), f);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
